// File: rtl/fjs_pkg.sv
// Shared types for the fork/join scheduler: join modes, FSM states and the
// raw mode-code decode used when a go request is accepted.
package fjs_pkg;

  localparam logic [1:0] MODE_ALL  = 2'd0;
  localparam logic [1:0] MODE_ANY  = 2'd1;
  localparam logic [1:0] MODE_NONE = 2'd2;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FORK      = 2'd1,
    JOIN_WAIT = 2'd2,
    TAIL_WAIT = 2'd3
  } fjs_state_e;

  // The reserved code 3 behaves as join-all.
  function automatic join_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      MODE_ALL:  return JOIN_ALL;
      MODE_ANY:  return JOIN_ANY;
      MODE_NONE: return JOIN_NONE;
      default:   return JOIN_ALL;
    endcase
  endfunction

endpackage

// File: rtl/fork_join_sched_if.sv
// Control and engine handshake bundle of the fork/join scheduler.
// The tmo_limit / err_tmo pair only exists when FJS_TIMEOUT_EN is defined.
interface fork_join_sched_if #(
  parameter int N_JOBS = 3
`ifdef FJS_TIMEOUT_EN
  , parameter int TMO_W = 16
`endif
);

  logic              go;
  logic [1:0]        mode;
  logic [N_JOBS-1:0] fork_mask;
  logic [N_JOBS-1:0] job_start;
  logic [N_JOBS-1:0] job_done;
  logic              tail_start;
  logic              tail_done;
  logic              ready;
  logic              joined;
  logic              finish;
  logic [N_JOBS-1:0] outstanding;
`ifdef FJS_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_limit;
  logic              err_tmo;
`endif

`ifdef FJS_TIMEOUT_EN
  modport master (
    output go, mode, fork_mask, job_done, tail_done, tmo_limit,
    input  job_start, tail_start, ready, joined, finish, outstanding, err_tmo
  );
  modport slave (
    input  go, mode, fork_mask, job_done, tail_done, tmo_limit,
    output job_start, tail_start, ready, joined, finish, outstanding, err_tmo
  );
`else
  modport master (
    output go, mode, fork_mask, job_done, tail_done,
    input  job_start, tail_start, ready, joined, finish, outstanding
  );
  modport slave (
    input  go, mode, fork_mask, job_done, tail_done,
    output job_start, tail_start, ready, joined, finish, outstanding
  );
`endif

endinterface

// File: rtl/fjs_done_tracker.sv
// Outstanding-job bookkeeping: loads the fork mask, clears bits on valid
// done pulses and remembers whether any forked job has completed.
module fjs_done_tracker #(
  parameter int N_JOBS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [N_JOBS-1:0] load_mask_i,
  input  logic              clear_i,
  input  logic [N_JOBS-1:0] job_start_i,
  input  logic [N_JOBS-1:0] job_done_i,
  output logic [N_JOBS-1:0] outstanding_o,
  output logic [N_JOBS-1:0] remain_o,
  output logic              any_done_o
);

  logic [N_JOBS-1:0] outstanding_q, outstanding_d;
  logic [N_JOBS-1:0] done_eff;
  logic              any_done_q, any_done_d;

  // A done counts only for a job still outstanding and not being started
  // in the same cycle (engines need at least one cycle to finish).
  for (genvar gi = 0; gi < N_JOBS; gi++) begin : g_bit
    assign done_eff[gi] = job_done_i[gi] & outstanding_q[gi] & ~job_start_i[gi];
  end

  // remain/any_done ignore load and clear so the FSM can use them without
  // feeding back into its own control decisions.
  assign remain_o      = outstanding_q & ~done_eff;
  assign any_done_o    = any_done_q | (|done_eff);
  assign outstanding_o = outstanding_q;

  // Next-state of the outstanding set: clear wins, then load, then dones.
  always_comb begin
    outstanding_d = remain_o;
    any_done_d    = any_done_o;
    if (clear_i) begin
      outstanding_d = '0;
      any_done_d    = 1'b0;
    end else if (load_i) begin
      outstanding_d = load_mask_i;
      any_done_d    = 1'b0;
    end
  end

  // Outstanding register and the sticky any-done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      any_done_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      any_done_q    <= any_done_d;
    end
  end

endmodule

// File: rtl/fork_join_sched.sv
// Fork/join scheduler: forks a group of job engines, waits on a join-all,
// join-any or join-none condition, then launches a single tail job.
// Optional macro FJS_TIMEOUT_EN adds a wait-state timeout with a sticky error.
module fork_join_sched
  import fjs_pkg::*;
#(
  parameter int N_JOBS = 3
`ifdef FJS_TIMEOUT_EN
  , parameter int TMO_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  fork_join_sched_if.slave bus
);

  fjs_state_e        state_q, state_d;
  join_mode_e        mode_q, mode_d;
  logic [N_JOBS-1:0] mask_q, mask_d;
  logic [N_JOBS-1:0] job_start_q, job_start_d;
  logic              tail_start_q, tail_start_d;
  logic              joined_q, joined_d;
  logic              finish_q, finish_d;
  logic              ready_q, ready_d;
  logic              accept, load, clear, join_cond;
  logic [N_JOBS-1:0] outstanding, remain;
  logic              any_done;
`ifdef FJS_TIMEOUT_EN
  logic [TMO_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              err_tmo_q, err_tmo_d;
  logic              in_wait;
`endif

  fjs_done_tracker #(.N_JOBS(N_JOBS)) u_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .load_mask_i   (bus.fork_mask),
    .clear_i       (clear),
    .job_start_i   (job_start_q),
    .job_done_i    (bus.job_done),
    .outstanding_o (outstanding),
    .remain_o      (remain),
    .any_done_o    (any_done)
  );

  // Join condition evaluated on the outstanding set after this cycle's dones.
  always_comb begin
    join_cond = 1'b0;
    case (mode_q)
      JOIN_ANY:  join_cond = any_done;
      JOIN_NONE: join_cond = 1'b1;
      default:   join_cond = (remain == '0);
    endcase
    if (mask_q == '0) join_cond = 1'b1;
  end

  // FSM next state and registered-output next values. joined/tail_start are
  // looked ahead so they are visible in the last JOIN_WAIT cycle.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    mask_d       = mask_q;
    job_start_d  = '0;
    tail_start_d = 1'b0;
    joined_d     = 1'b0;
    finish_d     = 1'b0;
    load         = 1'b0;
    clear        = 1'b0;
    accept       = bus.go & ready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = FORK;
          mode_d      = decode_mode(bus.mode);
          mask_d      = bus.fork_mask;
          job_start_d = bus.fork_mask;
          load        = 1'b1;
        end
      end
      FORK: begin
        state_d = JOIN_WAIT;
        if (join_cond) begin
          joined_d     = 1'b1;
          tail_start_d = 1'b1;
        end
      end
      JOIN_WAIT: begin
        if (joined_q) begin
          state_d = TAIL_WAIT;
        end else if (join_cond) begin
          joined_d     = 1'b1;
          tail_start_d = 1'b1;
        end
      end
      TAIL_WAIT: begin
        if (bus.tail_done) begin
          state_d  = IDLE;
          finish_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FJS_TIMEOUT_EN
    in_wait   = (state_q == JOIN_WAIT) || (state_q == TAIL_WAIT);
    cnt_inc   = cnt_q + TMO_W'(1);
    err_tmo_d = accept ? 1'b0 : err_tmo_q;
    // Normal progress takes priority over a timeout in the same cycle.
    if (in_wait && (state_d == state_q) && !joined_d &&
        (bus.tmo_limit != '0) && (cnt_inc == bus.tmo_limit)) begin
      state_d      = IDLE;
      joined_d     = 1'b0;
      tail_start_d = 1'b0;
      clear        = 1'b1;
      err_tmo_d    = 1'b1;
    end
    cnt_d = (in_wait && (state_d == state_q)) ? cnt_inc : '0;
`endif
    ready_d = (state_d == IDLE) && (clear || (remain == '0));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= JOIN_ALL;
      mask_q       <= '0;
      job_start_q  <= '0;
      tail_start_q <= 1'b0;
      joined_q     <= 1'b0;
      finish_q     <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      job_start_q  <= job_start_d;
      tail_start_q <= tail_start_d;
      joined_q     <= joined_d;
      finish_q     <= finish_d;
      ready_q      <= ready_d;
    end
  end

`ifdef FJS_TIMEOUT_EN
  // Wait-state cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign bus.err_tmo = err_tmo_q;
`endif

  assign bus.job_start   = job_start_q;
  assign bus.tail_start  = tail_start_q;
  assign bus.joined      = joined_q;
  assign bus.finish      = finish_q;
  assign bus.ready       = ready_q;
  assign bus.outstanding = outstanding;

endmodule

// File: tb/tb_fork_join_sched.sv
// Randomized bench for fork_join_sched. Each transaction is turned into an
// event timeline (start, join, tail, finish, ready cycles) from the join
// rules, and every cycle's outputs are compared against that timeline.
module tb_fork_join_sched;

  localparam int N_JOBS = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cur_txn;
  int   cur_cyc;
  logic exp_err_c0;

  always #5 clk = ~clk;

  fork_join_sched_if #(.N_JOBS(N_JOBS)) bus ();

  fork_join_sched #(.N_JOBS(N_JOBS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s txn=%0d cyc=%0d got=%0h exp=%0h", tag, cur_txn, cur_cyc, got, exp);
    end
  endtask

  task automatic check_cycle(input logic [2:0] e_js, input logic [2:0] e_out, input logic e_j,
                             input logic e_ts, input logic e_fin, input logic e_rdy);
    check_val("job_start",   32'(bus.job_start),   32'(e_js));
    check_val("outstanding", 32'(bus.outstanding), 32'(e_out));
    check_val("joined",      32'(bus.joined),      32'(e_j));
    check_val("tail_start",  32'(bus.tail_start),  32'(e_ts));
    check_val("finish",      32'(bus.finish),      32'(e_fin));
    check_val("ready",       32'(bus.ready),       32'(e_rdy));
  endtask

  task automatic drive_idle();
    bus.go        = 1'b0;
    bus.mode      = 2'd0;
    bus.fork_mask = '0;
    bus.job_done  = '0;
    bus.tail_done = 1'b0;
  endtask

  // One fork/join/tail transaction. Cycle 0 is the go cycle; d[i] is the
  // delay from the job_start cycle to job i's done; td is the delay from
  // tail_start to tail_done. noise adds pulses that must all be ignored.
  task automatic run_txn(input int mode, input logic [2:0] mask, input int d0, input int d1,
                         input int d2, input int td, input bit noise);
    int d [3];
    int s, j, t, f, r, e, maxd, mind, eff;
    logic [2:0] e_out;
    d[0] = d0; d[1] = d1; d[2] = d2;
    eff = (mode == 3) ? 0 : mode;
    s = 1;
    maxd = 0;
    mind = 1000;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        if (d[i] > maxd) maxd = d[i];
        if (d[i] < mind) mind = d[i];
      end
    end
    if (mask == 3'b000 || eff == 2) j = s + 1;
    else if (eff == 1)              j = s + mind + 1;
    else                            j = s + maxd + 1;
    t = j + td;
    f = t + 1;
    r = (mask == 3'b000) ? f : ((f > s + maxd + 1) ? f : s + maxd + 1);
    e = r + $urandom_range(0, 2);
    cur_txn++;
    $display("TXN %0d mode=%0d mask=%b noise=%0d join@%0d finish@%0d ready@%0d",
             cur_txn, mode, mask, noise, j, f, r);
    for (int c = 0; c <= e; c++) begin
      cur_cyc = c;
      bus.go        = 1'b0;
      bus.job_done  = '0;
      bus.tail_done = 1'b0;
      if (c == 0) begin
        bus.go        = 1'b1;
        bus.mode      = 2'(mode);
        bus.fork_mask = mask;
      end
      for (int i = 0; i < 3; i++)
        if (mask[i] && c == s + d[i]) bus.job_done[i] = 1'b1;
      if (c == t) bus.tail_done = 1'b1;
      if (noise) begin
        if (c >= s && c < r && $urandom_range(0, 3) == 0) begin
          bus.go        = 1'b1;
          bus.mode      = 2'($urandom);
          bus.fork_mask = 3'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
          if (!mask[i] && $urandom_range(0, 1) == 1) bus.job_done[i] = 1'b1;
          if (mask[i] && (c == 0 || c == s || c > s + d[i]) && $urandom_range(0, 2) == 0)
            bus.job_done[i] = 1'b1;
        end
        if ((c <= j || c > t) && $urandom_range(0, 3) == 0) bus.tail_done = 1'b1;
      end
      e_out = '0;
      for (int i = 0; i < 3; i++)
        if (mask[i] && c >= s && c <= s + d[i]) e_out[i] = 1'b1;
      @(negedge clk);
      check_cycle((c == s) ? mask : 3'b000, e_out, c == j, c == j, c == f, (c < s) || (c >= r));
`ifdef FJS_TIMEOUT_EN
      check_val("err_tmo", 32'(bus.err_tmo), 32'((c == 0) ? exp_err_c0 : 1'b0));
`endif
      @(posedge clk); #1;
    end
  endtask

  // Asynchronous reset in the middle of a join, then late done pulses.
  task automatic reset_abort();
    cur_txn++;
    cur_cyc = 0;
    $display("TXN %0d reset abort during join-all mask=111", cur_txn);
    drive_idle();
    bus.go        = 1'b1;
    bus.fork_mask = 3'b111;
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    cur_cyc = 2;
    @(negedge clk);
    check_val("abort_outstanding", 32'(bus.outstanding), 32'd7);
    check_val("abort_ready", 32'(bus.ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 cur_cyc = 3;
    check_cycle(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.job_done  = 3'b111;
    bus.tail_done = 1'b1;
    cur_cyc = 4;
    @(negedge clk);
    check_cycle(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive_idle();
    cur_cyc = 5;
    @(negedge clk);
    check_cycle(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

`ifdef FJS_TIMEOUT_EN
  // Join-all on job 0 that never completes; limit 5 cycles in JOIN_WAIT.
  task automatic timeout_txn(input logic err_before);
    cur_txn++;
    $display("TXN %0d timeout tmo_limit=5 mask=001", cur_txn);
    bus.tmo_limit = 16'd5;
    for (int c = 0; c <= 10; c++) begin
      cur_cyc = c;
      drive_idle();
      if (c == 0) begin
        bus.go        = 1'b1;
        bus.fork_mask = 3'b001;
      end
      @(negedge clk);
      check_cycle((c == 1) ? 3'b001 : 3'b000, (c >= 1 && c <= 6) ? 3'b001 : 3'b000,
                  1'b0, 1'b0, 1'b0, (c == 0) || (c >= 7));
      check_val("err_tmo", 32'(bus.err_tmo), 32'((c >= 7) ? 1'b1 : ((c == 0) ? err_before : 1'b0)));
      @(posedge clk); #1;
    end
    bus.tmo_limit = '0;
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cur_txn    = 0;
    cur_cyc    = 0;
    exp_err_c0 = 1'b0;
    rst_n      = 1'b0;
    drive_idle();
`ifdef FJS_TIMEOUT_EN
    bus.tmo_limit = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cycle(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef FJS_TIMEOUT_EN
    check_val("err_tmo_rst", 32'(bus.err_tmo), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(1, 3'b011, 10, 20, 0, 30, 1'b0);
    run_txn(0, 3'b011, 10, 20, 0, 30, 1'b0);
    run_txn(2, 3'b111, 4, 9, 14, 3, 1'b1);
    run_txn(0, 3'b000, 1, 1, 1, 4, 1'b1);
    run_txn(0, 3'b011, 6, 6, 0, 3, 1'b1);
    run_txn(3, 3'b101, 2, 0, 7, 2, 1'b1);
    reset_abort();

`ifdef FJS_TIMEOUT_EN
    timeout_txn(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 cur_cyc = 99;
    check_cycle(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("err_tmo_rst", 32'(bus.err_tmo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    timeout_txn(1'b0);
    exp_err_c0 = 1'b1;
    run_txn(0, 3'b010, 1, 3, 1, 2, 1'b0);
    exp_err_c0 = 1'b0;
`endif

    for (int k = 0; k < 30; k++) begin
      run_txn(int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
              int'($urandom_range(1, 12)), int'($urandom_range(1, 8)),
              $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
